// File: rtl/pixel_mem_pkg.sv
// Shared constants, bank index type and controller state encoding for the pixel store.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pixel_mem_pkg;

    // Default frame geometry: 640x480 pixels split over five banks
    localparam int FRAME_PIXELS = 307200;
    localparam int BANK_DEPTH   = 65000;
    localparam int NUM_BANKS    = 5;

    // Port widths shared by the writer and anything that talks to it
    localparam int PIX_ADDR_W   = 20;
    localparam int PIX_COUNT_W  = 19;
    localparam int PIX_DATA_W   = 8;

    // Index of one of the five banks (values 0..4)
    typedef logic [2:0] bankIdx_t;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FULL  = 2'd2
    } pixState_t;

    // Depth of the final, partially used bank
    function automatic int lastBankDepth(input int framePixels, input int bankDepth);
        return framePixels - (NUM_BANKS - 1) * bankDepth;
    endfunction

endpackage

// File: rtl/pixel_bank.sv
// One 8-bit pixel bank: single write port, synchronous read port.
// Latency: write lands on the edge wrEn is high; read data is valid 1 cycle after rdAddr.
// Backpressure: none; accepts a write and a read every cycle (read-during-write returns old data).
module pixel_bank #(
    parameter int DEPTH  = 65000,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [7:0]        wrData,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [7:0]        rdData
);

    // Contents are deliberately not reset; a clear pass initialises them
    logic [7:0] mem [DEPTH];

    // Write port and registered read port; non-blocking write gives read-old-data behaviour
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
        rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/pixel_store_writer.sv
// Pixel frame store: banked write pipeline, clear sequencer, write counter and registered read-back.
// Latency: accepted write visible to read-back 2 cycles later; read-back data 1 cycle after rd_addr.
// Backpressure: wr_ready low while clearing and once the frame is full; clr_req always wins over a write.
module pixel_store_writer #(
    parameter int FRAME_PIXELS = pixel_mem_pkg::FRAME_PIXELS,
    parameter int BANK_DEPTH   = pixel_mem_pkg::BANK_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [19:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        clr_req,
    input  logic [19:0] rd_addr,
    output logic [7:0]  rd_data,
    output logic [18:0] wr_count,
    output logic        frame_done,
    output logic        err_oob
);

    import pixel_mem_pkg::*;

    localparam int LAST_DEPTH = lastBankDepth(FRAME_PIXELS, BANK_DEPTH);
    localparam int OFF_W      = $clog2(BANK_DEPTH);

    // Bank start addresses; decoding is a ladder of compares, never a divide
    localparam logic [19:0] BND1       = 20'(BANK_DEPTH);
    localparam logic [19:0] BND2       = 20'(2 * BANK_DEPTH);
    localparam logic [19:0] BND3       = 20'(3 * BANK_DEPTH);
    localparam logic [19:0] BND4       = 20'(4 * BANK_DEPTH);
    localparam logic [19:0] ADDR_LIMIT = 20'(FRAME_PIXELS);
    localparam logic [18:0] COUNT_FULL = 19'(FRAME_PIXELS);

    localparam bankIdx_t          LAST_BANK      = bankIdx_t'(NUM_BANKS - 1);
    localparam logic [OFF_W-1:0]  LAST_OFF_BANK  = OFF_W'(BANK_DEPTH - 1);
    localparam logic [OFF_W-1:0]  LAST_OFF_FINAL = OFF_W'(LAST_DEPTH - 1);

    // Split a linear pixel address into bank, offset inside that bank and an out-of-range flag
    function automatic void decodeAddr(
        input  logic [19:0]      addr,
        output bankIdx_t         bank,
        output logic [OFF_W-1:0] offset,
        output logic             outOfRange
    );
        logic [19:0] base;
        if (addr >= BND4) begin
            bank = 3'd4;
            base = BND4;
        end else if (addr >= BND3) begin
            bank = 3'd3;
            base = BND3;
        end else if (addr >= BND2) begin
            bank = 3'd2;
            base = BND2;
        end else if (addr >= BND1) begin
            bank = 3'd1;
            base = BND1;
        end else begin
            bank = 3'd0;
            base = '0;
        end
        offset     = OFF_W'(addr - base);
        outOfRange = (addr >= ADDR_LIMIT);
    endfunction

    pixState_t          state;

    bankIdx_t           wrBank;
    logic [OFF_W-1:0]   wrOff;
    logic               wrOob;
    bankIdx_t           rdBank;
    logic [OFF_W-1:0]   rdOff;
    logic               rdOob;

    logic               wrAccept;
    logic               wrTake;
    logic [18:0]        wrCountNext;

    // Stage 1: decoded write waiting to be committed to its bank
    logic               s1Vld;
    bankIdx_t           s1Bank;
    logic [OFF_W-1:0]   s1Off;
    logic [7:0]         s1Data;

    // Clear sequencer position, tracked directly as bank/offset
    bankIdx_t           clrBank;
    logic [OFF_W-1:0]   clrOff;

    // Shared bank write port and read-back select
    logic [NUM_BANKS-1:0] memWe;
    logic [OFF_W-1:0]     memOff;
    logic [7:0]           memData;
    logic [7:0]           bankRdData [NUM_BANKS];
    bankIdx_t             rdBankQ;
    logic                 rdZeroQ;

    // A handshake happens whenever valid meets ready; clr_req in the same cycle discards it
    assign wrAccept    = wr_valid && wr_ready;
    assign wrTake      = wrAccept && !clr_req && !wrOob;
    assign wrCountNext = wr_count + 19'd1;

    // Write-side address decode
    always_comb begin
        decodeAddr(wr_addr, wrBank, wrOff, wrOob);
    end

    // Read-side address decode
    always_comb begin
        decodeAddr(rd_addr, rdBank, rdOff, rdOob);
    end

    // Control FSM: counting, sticky error, clear sequencing and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_ready   <= 1'b1;
            frame_done <= 1'b0;
            err_oob    <= 1'b0;
            wr_count   <= '0;
            clrBank    <= '0;
            clrOff     <= '0;
        end else if (clr_req) begin
            // A clear request (re)starts the sweep from address 0 in any state
            state      <= CLEAR;
            wr_ready   <= 1'b0;
            frame_done <= 1'b0;
            err_oob    <= 1'b0;
            wr_count   <= '0;
            clrBank    <= '0;
            clrOff     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wrAccept) begin
                        if (wrOob) begin
                            err_oob <= 1'b1;
                        end else begin
                            wr_count <= wrCountNext;
                            if (wrCountNext == COUNT_FULL) begin
                                state      <= FULL;
                                wr_ready   <= 1'b0;
                                frame_done <= 1'b1;
                            end
                        end
                    end
                end
                CLEAR: begin
                    // One address zeroed per cycle; leave right after the last pixel
                    if (clrBank == LAST_BANK && clrOff == LAST_OFF_FINAL) begin
                        state    <= IDLE;
                        wr_ready <= 1'b1;
                        clrBank  <= '0;
                        clrOff   <= '0;
                    end else if (clrOff == LAST_OFF_BANK) begin
                        clrBank <= clrBank + 3'd1;
                        clrOff  <= '0;
                    end else begin
                        clrOff <= clrOff + OFF_W'(1);
                    end
                end
                FULL: begin
                    state <= FULL;
                end
                default: begin
                    state    <= IDLE;
                    wr_ready <= 1'b1;
                end
            endcase
        end
    end

    // Stage-1 valid bit; reset drops any write still in the pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Vld <= 1'b0;
        end else begin
            s1Vld <= wrTake;
        end
    end

    // Stage-1 payload; only meaningful while s1Vld is set
    always_ff @(posedge clk) begin
        if (wrTake) begin
            s1Bank <= wrBank;
            s1Off  <= wrOff;
            s1Data <= wr_data;
        end
    end

    // Stage-2 write port: a pending pixel write first, otherwise the clear sweep
    always_comb begin
        memWe   = '0;
        memOff  = s1Off;
        memData = s1Data;
        if (!s1Vld && state == CLEAR) begin
            memOff  = clrOff;
            memData = 8'h00;
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (s1Vld) begin
                memWe[b] = (s1Bank == bankIdx_t'(b));
            end else if (state == CLEAR) begin
                memWe[b] = (clrBank == bankIdx_t'(b));
            end
        end
    end

    // Five banks: four full ones and a shorter last one
    for (genvar g = 0; g < NUM_BANKS; g++) begin : gBank
        localparam int BANK_SIZE = (g < NUM_BANKS - 1) ? BANK_DEPTH : LAST_DEPTH;
        pixel_bank #(
            .DEPTH  (BANK_SIZE),
            .ADDR_W (OFF_W)
        ) uBank (
            .clk    (clk),
            .wrEn   (memWe[g]),
            .wrAddr (memOff),
            .wrData (memData),
            .rdAddr (rdOff),
            .rdData (bankRdData[g])
        );
    end

    // Read-back select registered alongside the bank read; reset forces rd_data to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdZeroQ <= 1'b1;
            rdBankQ <= '0;
        end else begin
            rdZeroQ <= rdOob;
            rdBankQ <= rdBank;
        end
    end

    // Pick the registered word of the addressed bank; out-of-range reads return zero
    always_comb begin
        rd_data = 8'h00;
        if (!rdZeroQ) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (rdBankQ == bankIdx_t'(b)) begin
                    rd_data = bankRdData[b];
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_store_writer.sv
// Self-checking bench for pixel_store_writer using a scaled-down frame.
// Latency: checks 2-cycle write-to-readback and 1-cycle read latency.
// Backpressure: checks wr_ready during idle, clear and full states.
module tb_pixel_store_writer;

    localparam int F  = 1000;
    localparam int BD = 220;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [19:0] wr_addr;
    logic [7:0]  wr_data;
    logic        clr_req;
    logic [19:0] rd_addr;
    logic [7:0]  rd_data;
    logic [18:0] wr_count;
    logic        frame_done;
    logic        err_oob;

    pixel_store_writer #(
        .FRAME_PIXELS (F),
        .BANK_DEPTH   (BD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clr_req    (clr_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_count   (wr_count),
        .frame_done (frame_done),
        .err_oob    (err_oob)
    );

    always #5 clk = ~clk;

    // Reference model: frame contents, which pixels are defined, and status
    logic [7:0] refMem   [F];
    bit         refKnown [F];
    int         refCount;
    bit         refErr;
    bit         refFull;

    int numCompared   = 0;
    int numMismatched = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numCompared++;
        if (got !== exp) begin
            numMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic refClear();
        for (int a = 0; a < F; a++) begin
            refMem[a]   = 8'h00;
            refKnown[a] = 1'b1;
        end
        refCount = 0;
        refErr   = 1'b0;
        refFull  = 1'b0;
    endtask

    // Called at a falling edge; offers one write for one cycle
    task automatic doWrite(input int a, input logic [7:0] d);
        checkVal("wr_ready", 32'(wr_ready), 32'(!refFull));
        wr_valid = 1'b1;
        wr_addr  = 20'(a);
        wr_data  = d;
        if (!refFull) begin
            if (a < F) begin
                refMem[a]   = d;
                refKnown[a] = 1'b1;
                refCount++;
                if (refCount == F) refFull = 1'b1;
            end else begin
                refErr = 1'b1;
            end
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Called at a falling edge; presents rd_addr and checks the word one cycle later
    task automatic readCheck(input int a, input string tag);
        rd_addr = 20'(a);
        @(negedge clk);
        if (a >= F) begin
            checkVal(tag, 32'(rd_data), 32'h0);
        end else if (refKnown[a]) begin
            checkVal(tag, 32'(rd_data), 32'(refMem[a]));
        end
    endtask

    task automatic checkStatus(input string tag);
        checkVal({tag, "_count"}, 32'(wr_count), 32'(refCount));
        checkVal({tag, "_err"},   32'(err_oob),  32'(refErr));
        checkVal({tag, "_done"},  32'(frame_done), 32'(refFull));
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < F; a++) readCheck(a, tag);
    endtask

    // Counts falling edges with wr_ready low, bounded so a stuck clear still terminates
    task automatic waitClear(input int expCycles, input string tag);
        int cyc = 0;
        while (!wr_ready && cyc < expCycles + 20) begin
            cyc++;
            @(negedge clk);
        end
        checkVal(tag, 32'(cyc), 32'(expCycles));
        refClear();
    endtask

    task automatic runClear(input string tag);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        waitClear(F, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int bAddr [5];
        logic [7:0] bData [5];
        logic [7:0] oldVal;
        int a;

        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        clr_req  = 1'b0;
        rd_addr  = '0;
        refCount = 0;
        refErr   = 1'b0;
        refFull  = 1'b0;
        for (int i = 0; i < F; i++) refKnown[i] = 1'b0;

        // Reset values while reset is held
        #12;
        checkVal("rst_ready", 32'(wr_ready),   32'h1);
        checkVal("rst_count", 32'(wr_count),   32'h0);
        checkVal("rst_done",  32'(frame_done), 32'h0);
        checkVal("rst_err",   32'(err_oob),    32'h0);
        checkVal("rst_rd",    32'(rd_data),    32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // First write and read-back
        doWrite(0, 8'hA5);
        @(negedge clk);
        readCheck(0, "rd_first");
        checkStatus("first");

        // Initial clear makes every pixel defined
        runClear("clr_initial_cycles");
        checkStatus("after_clr");
        readCheck(0, "rd_cleared0");

        // Bank boundaries
        bAddr = '{BD - 1, BD, 4 * BD - 1, 4 * BD, F - 1};
        bData = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) doWrite(bAddr[i], bData[i]);
        @(negedge clk);
        for (int i = 0; i < 5; i++) readCheck(bAddr[i], "rd_boundary");
        readCheck(BD + 1, "rd_boundary_neighbour");
        readCheck(F, "rd_oob_addr");
        checkVal("boundary_count", 32'(wr_count), 32'd5);

        // Out-of-range writes
        doWrite(F, 8'hEE);
        @(negedge clk);
        checkStatus("oob");
        doWrite(20'hFFFFF, 8'h12);
        @(negedge clk);
        checkStatus("oob_max");
        sweep("sweep_oob");

        // Write-to-readback latency and read of a word being written
        oldVal = refMem[5];
        doWrite(5, 8'h77);
        rd_addr = 20'd5;
        @(negedge clk);
        checkVal("rd_during_write", 32'(rd_data), 32'(oldVal));
        @(negedge clk);
        checkVal("rd_two_cycles", 32'(rd_data), 32'h77);

        // clr_req coinciding with a write, then a restart mid-clear
        wr_valid = 1'b1;
        wr_addr  = 20'd7;
        wr_data  = 8'h99;
        clr_req  = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        checkVal("clr_prio_count", 32'(wr_count), 32'h0);
        checkVal("clr_prio_err",   32'(err_oob),  32'h0);
        repeat (299) @(negedge clk);
        checkVal("clr_busy_mid", 32'(wr_ready), 32'h0);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        waitClear(F, "clr_restart_cycles");
        checkStatus("after_restart");
        readCheck(7, "rd_clr_prio");
        readCheck(BD, "rd_after_restart");

        // Randomised writes with gaps, repeats and out-of-range addresses
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 9))
                    0:       a = int'($urandom_range(F, 20'hFFFFF));
                    1, 2:    a = int'($urandom_range(0, 15));
                    default: a = int'($urandom_range(0, F - 1));
                endcase
                doWrite(a, 8'($urandom));
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        checkStatus("random");
        sweep("sweep_random");

        // Fill the whole frame
        runClear("clr_before_fill_cycles");
        for (int i = 0; i < F; i++) doWrite(i, 8'(i) ^ 8'h5A);
        checkVal("fill_done",  32'(frame_done), 32'h1);
        checkVal("fill_ready", 32'(wr_ready),   32'h0);
        doWrite(3, 8'hFF);
        @(negedge clk);
        checkStatus("full");
        readCheck(0, "rd_full");
        readCheck(3, "rd_full");
        readCheck(BD, "rd_full");
        readCheck(F - 1, "rd_full");

        // Clear from FULL
        runClear("clr_full_cycles");
        checkStatus("after_full_clr");
        sweep("sweep_clr_full");

        // Reset in the middle of a clear
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (500) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkVal("rst_mid_ready", 32'(wr_ready),   32'h1);
        checkVal("rst_mid_count", 32'(wr_count),   32'h0);
        checkVal("rst_mid_done",  32'(frame_done), 32'h0);
        checkVal("rst_mid_rd",    32'(rd_data),    32'h0);
        @(negedge clk);
        rst = 1'b0;
        refCount = 0;
        refErr   = 1'b0;
        refFull  = 1'b0;
        @(negedge clk);
        checkVal("rst_rel_ready", 32'(wr_ready), 32'h1);
        doWrite(3, 8'h3C);
        @(negedge clk);
        readCheck(3, "rd_after_rst");
        checkStatus("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
